dubl_burst_arb: RTL and testbench

DUBL_BURST_ARB -- requirements
Module: dubl_burst_arb

---
 rtl/dubl_pkg.sv | 14 +
 rtl/dubl_burst_arb_rr_arb2.sv | 29 ++
 rtl/dubl_burst_arb.sv | 141 ++++++++++++++
 tb/tb_dubl_burst_arb.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dubl_pkg.sv
// Shared definitions for the dubl burst arbiter.
// Contents: burst FSM state encoding and the default burst-length width.
package dubl_pkg;

  localparam int DUBL_LEN_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_GAP  = 2'd3
  } dubl_state_e;

endpackage

// File: rtl/dubl_burst_arb_rr_arb2.sv
// Two-way round-robin selector.
// Ports:
//   clk_in, rst : block clock, async active-high reset
//   req[1:0]    : request vector (bit N = requester N)
//   take        : the current selection is being accepted this cycle
//   gnt[1:0]    : one-hot selection (combinational)
// The priority flop points at the requester that wins the next tie; it
// moves away from whoever was just accepted. Reset favours requester 0.
module rr_arb2 (
  input  logic       clk_in,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

  logic prio1;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = prio1 ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)       prio1 <= 1'b0;
    else if (take) prio1 <= gnt[0];
  end

endmodule

// File: rtl/dubl_burst_arb.sv
// Burst arbiter for a shared double-edge pulse generator.
// Two requesters compete for the generator; the winner gets a burst of
// len clk_in cycles (two edge pulses per cycle) of gen_en.
// Ports:
//   clk_in, rst          : block clock, async active-high reset
//   req0/1, len0/1       : level requests and burst lengths (sampled at grant)
//   gnt0/1               : current owner of the generator
//   done0/1, abort0/1    : one-cycle completion / abort pulses
//   gen_en, gen_rst_n    : generator output gate and phase re-init (active low)
//   edge_cnt             : edge pulses delivered in the current/last burst
//   busy                 : FSM not idle
//
// state | meaning
// IDLE  | waiting for a request; arbitration happens here
// ARM   | owner granted, generator phase re-init (gen_rst_n low)
// RUN   | generator enabled, one burst cycle per clock
// GAP   | owner released, done/abort pulse, mandatory spacer before IDLE
module dubl_burst_arb
  import dubl_pkg::*;
#(
  parameter int LEN_W = DUBL_LEN_W
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             req0,
  input  logic [LEN_W-1:0] len0,
  input  logic             req1,
  input  logic [LEN_W-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             abort0,
  output logic             abort1,
  output logic             gen_en,
  output logic             gen_rst_n,
  output logic [LEN_W:0]   edge_cnt,
  output logic             busy
);

  dubl_state_e      state;
  logic             owner;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] rem;
  logic [1:0]       arb_gnt;
  logic             arb_take;
  logic             owner_req;

  // Only the owner's request matters once a burst is under way.
  assign owner_req = owner ? req1 : req0;
  assign arb_take  = (state == ST_IDLE) && (req0 || req1);

  rr_arb2 u_rr_arb2 (
    .clk_in (clk_in),
    .rst    (rst),
    .req    ({req1, req0}),
    .take   (arb_take),
    .gnt    (arb_gnt)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= 1'b0;
      len_q     <= '0;
      rem       <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      abort0    <= 1'b0;
      abort1    <= 1'b0;
      gen_en    <= 1'b0;
      gen_rst_n <= 1'b0;
      edge_cnt  <= '0;
      busy      <= 1'b0;
    end else begin
      done0  <= 1'b0;
      done1  <= 1'b0;
      abort0 <= 1'b0;
      abort1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          gen_rst_n <= 1'b1;
          if (arb_take) begin
            state     <= ST_ARM;
            busy      <= 1'b1;
            owner     <= arb_gnt[1];
            gnt0      <= arb_gnt[0];
            gnt1      <= arb_gnt[1];
            len_q     <= arb_gnt[1] ? len1 : len0;
            edge_cnt  <= '0;
            gen_rst_n <= 1'b0;
          end
        end
        ST_ARM: begin
          gen_rst_n <= 1'b1;
          if (!owner_req || len_q == '0) begin
            state  <= ST_GAP;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= owner_req && !owner;
            done1  <= owner_req && owner;
            abort0 <= !owner_req && !owner;
            abort1 <= !owner_req && owner;
          end else begin
            state    <= ST_RUN;
            gen_en   <= 1'b1;
            rem      <= len_q - LEN_W'(1);
            edge_cnt <= edge_cnt + (LEN_W+1)'(2);
          end
        end
        ST_RUN: begin
          // rem counts RUN cycles still to go after the current one.
          if (!owner_req || rem == '0) begin
            state  <= ST_GAP;
            gen_en <= 1'b0;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= owner_req && !owner;
            done1  <= owner_req && owner;
            abort0 <= !owner_req && !owner;
            abort1 <= !owner_req && owner;
          end else begin
            rem      <= rem - LEN_W'(1);
            edge_cnt <= edge_cnt + (LEN_W+1)'(2);
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dubl_burst_arb.sv
// Directed bench for dubl_burst_arb: a per-cycle vector table followed by
// hand-written sequences for reset mid-burst and the maximum-length burst.
module tb_dubl_burst_arb;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] len0, len1;
  logic       gnt0, gnt1, done0, done1, abort0, abort1;
  logic       gen_en, gen_rst_n, busy;
  logic [8:0] edge_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  dubl_burst_arb #(.LEN_W(8)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .req0      (req0),
    .len0      (len0),
    .req1      (req1),
    .len1      (len1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .abort0    (abort0),
    .abort1    (abort1),
    .gen_en    (gen_en),
    .gen_rst_n (gen_rst_n),
    .edge_cnt  (edge_cnt),
    .busy      (busy)
  );

  typedef struct {
    string      name;
    logic       r0;
    logic [7:0] l0;
    logic       r1;
    logic [7:0] l1;
    logic [8:0] flags;  // {gnt0,gnt1,gen_en,gen_rst_n,done0,done1,abort0,abort1,busy}
    logic [8:0] ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic r0, int l0, logic r1, int l1,
                              logic g0, logic g1, logic en, logic rn,
                              logic d0, logic d1, logic a0, logic a1,
                              logic bz, int ec);
    vec_t v;
    v.name  = nm;
    v.r0    = r0;
    v.l0    = 8'(l0);
    v.r1    = r1;
    v.l1    = 8'(l1);
    v.flags = {g0, g1, en, rn, d0, d1, a0, a1, bz};
    v.ec    = 9'(ec);
    return v;
  endfunction

  function automatic logic [8:0] flags_now();
    return {gnt0, gnt1, gen_en, gen_rst_n, done0, done1, abort0, abort1, busy};
  endfunction

  task automatic check(string nm, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, actual, expected);
    end
  endtask

  // Advance one clock and sample 1ns after the edge; also enforce the
  // grant invariants on every cycle.
  task automatic tick();
    @(posedge clk_in);
    #1;
    check("gnt_mutex", int'(gnt0 && gnt1), 0);
    check("gen_en_needs_gnt", int'(gen_en && !(gnt0 || gnt1)), 0);
  endtask

  initial begin
    int en_cnt;
    int done_at;

    //        name    r0 l0  r1 l1   g0 g1 en rn d0 d1 a0 a1 bz ec
    tbl.push_back(mk("idle0", 0, 0,  0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    // requester 0 alone, len 3
    tbl.push_back(mk("a1",    1, 3,  0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("a2",    1, 3,  0, 0,  1, 0, 1, 1, 0, 0, 0, 0, 1, 2));
    tbl.push_back(mk("a3",    1, 3,  0, 0,  1, 0, 1, 1, 0, 0, 0, 0, 1, 4));
    tbl.push_back(mk("a4",    1, 3,  0, 0,  1, 0, 1, 1, 0, 0, 0, 0, 1, 6));
    tbl.push_back(mk("a5",    1, 3,  0, 0,  0, 0, 0, 1, 1, 0, 0, 0, 1, 6));
    tbl.push_back(mk("a6",    0, 3,  0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 6));
    // requester 1 alone, len 0
    tbl.push_back(mk("b1",    0, 0,  1, 0,  0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("b2",    0, 0,  1, 0,  0, 0, 0, 1, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk("b3",    0, 0,  0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    // both held, len 2 each: 0, then 1, then 0 again; last one aborted in ARM
    tbl.push_back(mk("c1",    1, 2,  1, 2,  1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("c2",    1, 2,  1, 2,  1, 0, 1, 1, 0, 0, 0, 0, 1, 2));
    tbl.push_back(mk("c3",    1, 2,  1, 2,  1, 0, 1, 1, 0, 0, 0, 0, 1, 4));
    tbl.push_back(mk("c4",    1, 2,  1, 2,  0, 0, 0, 1, 1, 0, 0, 0, 1, 4));
    tbl.push_back(mk("c5",    1, 2,  1, 2,  0, 0, 0, 1, 0, 0, 0, 0, 0, 4));
    tbl.push_back(mk("c6",    1, 2,  1, 2,  0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("c7",    1, 2,  1, 2,  0, 1, 1, 1, 0, 0, 0, 0, 1, 2));
    tbl.push_back(mk("c8",    1, 2,  1, 2,  0, 1, 1, 1, 0, 0, 0, 0, 1, 4));
    tbl.push_back(mk("c9",    1, 2,  1, 2,  0, 0, 0, 1, 0, 1, 0, 0, 1, 4));
    tbl.push_back(mk("c10",   1, 2,  1, 2,  0, 0, 0, 1, 0, 0, 0, 0, 0, 4));
    tbl.push_back(mk("c11",   1, 2,  1, 2,  1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("c12",   0, 2,  0, 2,  0, 0, 0, 1, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk("c13",   0, 2,  0, 2,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    // requester 0 len 10, dropped after 4 RUN cycles; req1 toggles meanwhile
    tbl.push_back(mk("d1",    1, 10, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("d2",    1, 10, 1, 0,  1, 0, 1, 1, 0, 0, 0, 0, 1, 2));
    tbl.push_back(mk("d3",    1, 10, 0, 0,  1, 0, 1, 1, 0, 0, 0, 0, 1, 4));
    tbl.push_back(mk("d4",    1, 10, 1, 0,  1, 0, 1, 1, 0, 0, 0, 0, 1, 6));
    tbl.push_back(mk("d5",    1, 10, 0, 0,  1, 0, 1, 1, 0, 0, 0, 0, 1, 8));
    tbl.push_back(mk("d6",    0, 10, 0, 0,  0, 0, 0, 1, 0, 0, 1, 0, 1, 8));
    tbl.push_back(mk("d7",    0, 10, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 8));

    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    len0 = '0;
    len1 = '0;
    #12;
    check("reset_flags", int'(flags_now()), 0);
    check("reset_edge_cnt", int'(edge_cnt), 0);
    @(negedge clk_in);
    rst = 1'b0;

    foreach (tbl[i]) begin
      req0 = tbl[i].r0;
      len0 = tbl[i].l0;
      req1 = tbl[i].r1;
      len1 = tbl[i].l1;
      tick();
      check({tbl[i].name, "_flags"}, int'(flags_now()), int'(tbl[i].flags));
      check({tbl[i].name, "_edge_cnt"}, int'(edge_cnt), int'(tbl[i].ec));
    end

    // Reset in the middle of a len 5 burst.
    req0 = 1'b1;
    len0 = 8'd5;
    tick();
    tick();
    tick();
    check("pre_rst_gen_en", int'(gen_en), 1);
    check("pre_rst_edge_cnt", int'(edge_cnt), 4);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_flags", int'(flags_now()), 0);
    check("async_rst_edge_cnt", int'(edge_cnt), 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("held_rst_flags", int'(flags_now()), 0);
    end
    req0 = 1'b0;
    rst  = 1'b0;
    tick();
    check("post_rst_idle", int'(flags_now()), int'(9'b000100000));
    // Tie right after reset must go to requester 0 again.
    req0 = 1'b1;
    req1 = 1'b1;
    len0 = 8'd1;
    len1 = 8'd1;
    tick();
    check("post_rst_tie", int'(flags_now()), int'(9'b100000001));
    tick();
    check("post_rst_run", int'(flags_now()), int'(9'b101100001));
    tick();
    check("post_rst_done", int'(flags_now()), int'(9'b000110001));
    check("post_rst_edge_cnt", int'(edge_cnt), 2);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    check("post_rst_back_idle", int'(flags_now()), int'(9'b000100000));

    // Longest burst: 255 RUN cycles, done at cycle 257 after grant.
    req0    = 1'b1;
    len0    = 8'd255;
    en_cnt  = 0;
    done_at = 0;
    for (int c = 1; c <= 400; c++) begin
      tick();
      if (gen_en) en_cnt++;
      if (done0) begin
        done_at = c;
        break;
      end
    end
    check("max_done_cycle", done_at, 257);
    check("max_gen_en_cycles", en_cnt, 255);
    check("max_edge_cnt", int'(edge_cnt), 510);
    req0 = 1'b0;
    tick();
    check("max_back_idle", int'(flags_now()), int'(9'b000100000));
    check("max_edge_cnt_hold", int'(edge_cnt), 510);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
